// File: rtl/audio_clock_regeneration_decoder.sv
// audio_clock_regeneration_decoder
//   Sink side of the HDMI Audio Clock Regeneration packet. Accepts decoded
//   data-island packets with HB0 = 0x01, confirms that all four subpackets
//   carry the same N/CTS, commits N/CTS, and regenerates 128*fs and fs
//   enables from the pixel clock with a DDA (N ticks per CTS cycles).
//
//   Ports:
//     clk_pixel     pixel clock, all logic in this domain
//     reset         asynchronous, active-high
//     packet_valid  one-cycle strobe, header/sub hold a complete packet
//     header        {HB2,HB1,HB0}
//     sub           four 56-bit subpackets
//     n_out/cts_out committed N / CTS
//     acr_valid     a packet has been committed since reset
//     acr_locked    stable N/CTS (lock detector) or acr_valid
//     packet_error  one-cycle pulse on a rejected ACR packet
//     tick_128fs    one-cycle enable at average rate f_pixel*N/CTS
//     tick_fs       one-cycle enable on every 128th tick_128fs
//
//   Build option: define ACR_LOCK_DETECT_EN to enable the lock counter
//   (LOCK_COUNT consecutive consistent commits). Without it acr_locked
//   simply follows acr_valid.
module audio_clock_regeneration_decoder #(
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic            clk_pixel,
    input  logic            reset,
    input  logic            packet_valid,
    input  logic [23:0]     header,
    input  logic [3:0][55:0] sub,
    output logic [19:0]     n_out,
    output logic [19:0]     cts_out,
    output logic            acr_valid,
    output logic            acr_locked,
    output logic            packet_error,
    output logic            tick_128fs,
    output logic            tick_fs
);

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic        mismatch_q, mismatch_d;
    logic [19:0] n_cap_q [4];
    logic [19:0] n_cap_d [4];
    logic [19:0] cts_cap_q [4];
    logic [19:0] cts_cap_d [4];
    logic [19:0] n_q, n_d, cts_q, cts_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [19:0] acc_q, acc_d;
    logic [6:0]  div_q, div_d;
    logic        tick_q, tick_d, fs_q, fs_d;
    logic [20:0] sum;
    logic        commit_ok, commit_fail;

    // Fields not carrying N/CTS are ignored.
    logic unused_bits;
    always_comb begin
        unused_bits = ^header[23:8];
        for (int unsigned i = 0; i < 4; i++)
            unused_bits = unused_bits ^ (^sub[i][39:36]) ^ (^sub[i][15:12]) ^ (^sub[i][7:0]);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mismatch_d  = mismatch_q;
        n_cap_d     = n_cap_q;
        cts_cap_d   = cts_cap_q;
        n_d         = n_q;
        cts_d       = cts_q;
        valid_d     = valid_q;
        err_d       = 1'b0;
        acc_d       = acc_q;
        div_d       = div_q;
        tick_d      = 1'b0;
        fs_d        = 1'b0;
        commit_ok   = 1'b0;
        commit_fail = 1'b0;

        // DDA step: acc stays below cts_q, so one subtraction suffices.
        sum = {1'b0, acc_q} + {1'b0, n_q};
        if (valid_q) begin
            if (sum >= {1'b0, cts_q}) begin
                acc_d  = 20'(sum - {1'b0, cts_q});
                tick_d = 1'b1;
            end else begin
                acc_d = sum[19:0];
            end
        end
        if (tick_d) begin
            div_d = div_q + 7'd1;
            fs_d  = (div_q == 7'd127);
        end

        case (state_q)
            IDLE: begin
                if (packet_valid && header[7:0] == 8'h01) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        n_cap_d[i]   = {sub[i][35:32], sub[i][47:40], sub[i][55:48]};
                        cts_cap_d[i] = {sub[i][11:8],  sub[i][23:16], sub[i][31:24]};
                    end
                    k_d        = 2'd0;
                    mismatch_d = 1'b0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (n_cap_q[k_q] != n_cap_q[0] || cts_cap_q[k_q] != cts_cap_q[0])
                    mismatch_d = 1'b1;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3)
                    state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (mismatch_q || n_cap_q[0] == '0 || cts_cap_q[0] == '0 ||
                    n_cap_q[0] >= cts_cap_q[0]) begin
                    err_d       = 1'b1;
                    commit_fail = 1'b1;
                end else begin
                    commit_ok = 1'b1;
                    n_d       = n_cap_q[0];
                    cts_d     = cts_cap_q[0];
                    valid_d   = 1'b1;
                    // A new N restarts the phase; a CTS-only change keeps the
                    // phase but clamps it into the new range. This cycle's
                    // step is discarded in both cases.
                    if (n_cap_q[0] != n_q) begin
                        acc_d  = '0;
                        div_d  = '0;
                        tick_d = 1'b0;
                        fs_d   = 1'b0;
                    end else if (cts_cap_q[0] != cts_q) begin
                        acc_d  = (acc_q >= cts_cap_q[0]) ? '0 : acc_q;
                        div_d  = div_q;
                        tick_d = 1'b0;
                        fs_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            mismatch_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                n_cap_q[i]   <= '0;
                cts_cap_q[i] <= '0;
            end
            n_q        <= '0;
            cts_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            acc_q      <= '0;
            div_q      <= '0;
            tick_q     <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            mismatch_q <= mismatch_d;
            n_cap_q    <= n_cap_d;
            cts_cap_q  <= cts_cap_d;
            n_q        <= n_d;
            cts_q      <= cts_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            fs_q       <= fs_d;
        end
    end

`ifdef ACR_LOCK_DETECT_EN
    localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 1);

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic [19:0]       cts_delta;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        cts_delta  = (cts_cap_q[0] >= cts_q) ? cts_cap_q[0] - cts_q : cts_q - cts_cap_q[0];
        if (commit_fail) begin
            lock_cnt_d = '0;
        end else if (commit_ok) begin
            if (!valid_q)
                lock_cnt_d = LOCK_W'(1);
            else if (n_cap_q[0] == n_q && cts_delta <= 20'd1)
                lock_cnt_d = (lock_cnt_q == LOCK_W'(LOCK_COUNT)) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
            else
                lock_cnt_d = '0;
        end
        locked_d = (lock_cnt_d == LOCK_W'(LOCK_COUNT));
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign acr_locked = locked_q;
`else
    localparam int unsigned UNUSED_LOCK_COUNT = LOCK_COUNT;
    logic unused_commit;
    assign unused_commit = commit_ok ^ commit_fail;
    assign acr_locked    = valid_q;
`endif

    assign n_out        = n_q;
    assign cts_out      = cts_q;
    assign acr_valid    = valid_q;
    assign packet_error = err_q;
    assign tick_128fs   = tick_q;
    assign tick_fs      = fs_q;

endmodule

// File: tb/tb_audio_clock_regeneration_decoder.sv
// Scoreboard bench for audio_clock_regeneration_decoder: the driver predicts
// each ACR packet's outcome and queues it with its due cycle; a negedge
// monitor applies outcomes to a reference model and compares every output
// every cycle, with tick timing derived from floor(k*N/CTS).
module tb_audio_clock_regeneration_decoder;

    logic             clk_pixel = 1'b0;
    logic             reset = 1'b1;
    logic             packet_valid = 1'b0;
    logic [23:0]      header = '0;
    logic [3:0][55:0] sub = '0;
    logic [19:0]      n_out, cts_out;
    logic             acr_valid, acr_locked, packet_error, tick_128fs, tick_fs;

    audio_clock_regeneration_decoder #(.LOCK_COUNT(3)) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .packet_valid (packet_valid),
        .header       (header),
        .sub          (sub),
        .n_out        (n_out),
        .cts_out      (cts_out),
        .acr_valid    (acr_valid),
        .acr_locked   (acr_locked),
        .packet_error (packet_error),
        .tick_128fs   (tick_128fs),
        .tick_fs      (tick_fs)
    );

    always #5 clk_pixel = ~clk_pixel;

    int unsigned cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    int unsigned n_pass = 0, n_total = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int unsigned t;
        bit          err;
        logic [19:0] n;
        logic [19:0] cts;
    } outcome_t;
    outcome_t q[$];

    // Reference model state
    bit          m_valid = 0;
    logic [19:0] m_n = '0, m_cts = '0;
    bit          tick_ok = 1;
    int unsigned start = 0;
    int          lock_cnt = 0;
    int unsigned busy_until = 0;
    int unsigned last_ts = 0;

    bit          mon_err;
    bit          e_tick, e_fs;
    longint      mk, t0, t1;
    outcome_t    e;

    always @(negedge clk_pixel) begin
        mon_err = 0;
        while (q.size() > 0 && q[0].t == cyc) begin
            e = q.pop_front();
            if (e.err) begin
                mon_err  = 1;
                lock_cnt = 0;
            end else begin
                if (!m_valid) lock_cnt = 1;
                else if (e.n == m_n && (e.cts == m_cts || e.cts == m_cts + 1 || e.cts + 1 == m_cts))
                    lock_cnt = (lock_cnt < 3) ? lock_cnt + 1 : 3;
                else lock_cnt = 0;
                if (!m_valid || e.n != m_n) begin
                    tick_ok = 1;
                    start   = cyc;
                end else if (e.cts != m_cts) begin
                    tick_ok = 0;
                end
                m_n     = e.n;
                m_cts   = e.cts;
                m_valid = 1;
            end
        end
        chk("n_out", 64'(n_out), 64'(m_n));
        chk("cts_out", 64'(cts_out), 64'(m_cts));
        chk("acr_valid", 64'(acr_valid), 64'(m_valid));
        chk("packet_error", 64'(packet_error), 64'(mon_err));
`ifdef ACR_LOCK_DETECT_EN
        chk("acr_locked", 64'(acr_locked), 64'(lock_cnt == 3));
`else
        chk("acr_locked", 64'(acr_locked), 64'(m_valid));
`endif
        if (!m_valid || tick_ok) begin
            e_tick = 0;
            e_fs   = 0;
            if (m_valid && cyc > start) begin
                mk = longint'(cyc - start);
                t1 = (mk * longint'(m_n)) / longint'(m_cts);
                t0 = ((mk - 1) * longint'(m_n)) / longint'(m_cts);
                e_tick = (t1 != t0);
                e_fs   = e_tick && (t1 % 128 == 0);
            end
            chk("tick_128fs", 64'(tick_128fs), 64'(e_tick));
            chk("tick_fs", 64'(tick_fs), 64'(e_fs));
        end
    end

    task automatic send(input logic [7:0] hb0, input logic [19:0] n[4], input logic [19:0] cts[4]);
        logic [3:0][55:0] s;
        outcome_t         o;
        bit               agree;
        @(negedge clk_pixel);
        for (int k = 0; k < 4; k++) begin
            s[k] = 56'({$urandom(), $urandom()});
            s[k][55:48] = n[k][7:0];
            s[k][47:40] = n[k][15:8];
            s[k][35:32] = n[k][19:16];
            s[k][31:24] = cts[k][7:0];
            s[k][23:16] = cts[k][15:8];
            s[k][11:8]  = cts[k][19:16];
        end
        sub          = s;
        header       = {16'($urandom()), hb0};
        packet_valid = 1'b1;
        last_ts      = cyc;
        if (hb0 == 8'h01 && cyc >= busy_until) begin
            busy_until = cyc + 6;
            agree = 1;
            for (int k = 1; k < 4; k++)
                if (n[k] != n[0] || cts[k] != cts[0]) agree = 0;
            o.t   = cyc + 6;
            o.err = !agree || n[0] == 0 || cts[0] == 0 || n[0] >= cts[0];
            o.n   = n[0];
            o.cts = cts[0];
            q.push_back(o);
        end
        @(negedge clk_pixel);
        packet_valid = 1'b0;
    endtask

    task automatic send_same(input logic [7:0] hb0, input logic [19:0] n, input logic [19:0] cts);
        logic [19:0] na[4];
        logic [19:0] ca[4];
        for (int k = 0; k < 4; k++) begin
            na[k] = n;
            ca[k] = cts;
        end
        send(hb0, na, ca);
    endtask

    task automatic idle(input int unsigned c);
        repeat (c) @(negedge clk_pixel);
    endtask

    task automatic do_reset();
        @(negedge clk_pixel);
        #2;
        reset        = 1'b1;
        packet_valid = 1'b0;
        q.delete();
        m_valid = 0; m_n = '0; m_cts = '0; tick_ok = 1; lock_cnt = 0; busy_until = 0;
        #1;
        chk("rst n_out", 64'(n_out), 64'd0);
        chk("rst cts_out", 64'(cts_out), 64'd0);
        chk("rst acr_valid", 64'(acr_valid), 64'd0);
        chk("rst acr_locked", 64'(acr_locked), 64'd0);
        chk("rst packet_error", 64'(packet_error), 64'd0);
        chk("rst tick_128fs", 64'(tick_128fs), 64'd0);
        chk("rst tick_fs", 64'(tick_fs), 64'd0);
        repeat (2) @(negedge clk_pixel);
        #2;
        reset = 1'b0;
    endtask

    task automatic count_window(input string name, input int unsigned len,
                                input int unsigned exp_t, input int unsigned exp_f);
        int unsigned target, nt, nf;
        target = last_ts + 6;
        while (cyc < target) @(negedge clk_pixel);
        nt = 0;
        nf = 0;
        repeat (len) begin
            @(negedge clk_pixel);
            nt += 32'(tick_128fs);
            nf += 32'(tick_fs);
        end
        chk({name, " tick_128fs count"}, 64'(nt), 64'(exp_t));
        chk({name, " tick_fs count"}, 64'(nf), 64'(exp_f));
    endtask

    initial begin
        logic [19:0] na[4];
        logic [19:0] ca[4];
        int unsigned c, n, sel;

        do_reset();

        // Reference rate: 6144 ticks and 48 fs ticks per 25200 cycles
        send_same(8'h01, 20'd6144, 20'd25200);
        count_window("48k", 25200, 6144, 48);
        chk("48k n_out", 64'(n_out), 64'd6144);

        // One subpacket disagrees on CTS
        for (int k = 0; k < 4; k++) begin na[k] = 20'd6144; ca[k] = 20'd25200; end
        ca[2] = 20'd25201;
        send(8'h01, na, ca);
        idle(10);
        chk("mismatch keeps cts", 64'(cts_out), 64'd25200);

        // Illegal N: no commit from reset state
        do_reset();
        send_same(8'h01, 20'd30000, 20'd25200);
        idle(8);
        send_same(8'h01, 20'd0, 20'd25200);
        idle(40);
        chk("illegal acr_valid", 64'(acr_valid), 64'd0);

        // Other packet types ignored; strobe during CHECK dropped
        send_same(8'h02, 20'd6144, 20'd25200);
        idle(8);
        send_same(8'h01, 20'd1000, 20'd3000);
        send_same(8'h01, 20'd2000, 20'd3000);
        idle(20);
        chk("busy drop n_out", 64'(n_out), 64'd1000);
        count_window("1000/3000", 3000, 1000, 7);

        // Lock sequence
        do_reset();
        send_same(8'h01, 20'd6144, 20'd25200); idle(8);
        send_same(8'h01, 20'd6144, 20'd25201); idle(8);
        send_same(8'h01, 20'd6144, 20'd25200); idle(8);
        chk("lock after 3", 64'(acr_locked), 64'd1);
        send_same(8'h01, 20'd6144, 20'd25210); idle(8);
`ifdef ACR_LOCK_DETECT_EN
        chk("lock cleared", 64'(acr_locked), 64'd0);
`else
        chk("lock follows valid", 64'(acr_locked), 64'd1);
`endif

        // Reset during CHECK, then a clean packet, then reset while ticking
        do_reset();
        send_same(8'h01, 20'd441, 20'd2000);
        do_reset();
        idle(10);
        chk("no commit after abort", 64'(acr_valid), 64'd0);
        send_same(8'h01, 20'd441, 20'd2000);
        count_window("441/2000", 2000, 441, 3);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            c   = $urandom_range(1500, 64);
            n   = $urandom_range(c - 1, 1);
            sel = $urandom_range(15, 0);
            if (sel == 0) n = 0;
            else if (sel == 1) n = c + $urandom_range(50, 0);
            else if (sel == 2 && m_valid) begin n = 32'(m_n); c = 32'(m_cts) + 1; end
            for (int k = 0; k < 4; k++) begin na[k] = 20'(n); ca[k] = 20'(c); end
            if (sel == 3) na[$urandom_range(3, 1)] = 20'(n + 1);
            if (sel == 4) ca[$urandom_range(3, 1)] = 20'(c + 1);
            send((sel == 5) ? 8'(8'h80 + $urandom_range(3, 0)) : 8'h01, na, ca);
            idle($urandom_range(300, 0));
        end

        idle(10);
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
